// File: rtl/key_code_lock_if.sv
// rtl/key_code_lock_if.sv - keypad lock bundle: debounced key levels in, display/actuator signals out
interface key_code_lock_if;
   logic [15:0] key_deb;
   logic [15:0] entry;
   logic [2:0]  digit_cnt;
   logic        digit_valid;
   logic        unlock;
   logic        fail;
   logic        locked;
   logic [2:0]  tries_used;

   modport master (
      output key_deb,
      input  entry, digit_cnt, digit_valid, unlock, fail, locked, tries_used
   );

   modport slave (
      input  key_deb,
      output entry, digit_cnt, digit_valid, unlock, fail, locked, tries_used
   );
endinterface

// File: rtl/key_code_lock.sv
// rtl/key_code_lock.sv - 4-digit keypad code lock with failed-try lockout
// Optional AUTO_RELOCK_EN: OPEN relocks by itself after OPEN_CYCLES cycles.
module key_code_lock #(
   parameter logic [15:0] CODE        = 16'h1234,
   parameter int unsigned MAX_TRIES   = 5,
   parameter logic [31:0] LOCK_CYCLES = 32'd50_000_000,
   parameter logic [31:0] OPEN_CYCLES = 32'd250_000_000
) (
   input logic            clk,
   input logic            rstn,
   key_code_lock_if.slave lk
);

   localparam logic [2:0] MAX_T = 3'(MAX_TRIES);

   typedef enum logic [1:0] {
      ST_ENTRY,
      ST_CHECK,
      ST_OPEN,
      ST_LOCKOUT
   } state_t;

   state_t      state_q;
   logic [15:0] key_prev_q;
   logic [15:0] entry_q;
   logic [2:0]  digit_cnt_q;
   logic [2:0]  tries_q;
   logic        digit_valid_q;
   logic        unlock_q;
   logic        fail_q;
   logic        locked_q;
   logic [31:0] lock_cnt_q;
`ifdef AUTO_RELOCK_EN
   logic [31:0] open_cnt_q;
`else
   logic        unused_open_cycles;
   assign unused_open_cycles = ^OPEN_CYCLES;
`endif

   logic [15:0] rise_d;
   logic        press_d;
   logic [3:0]  idx_d;
   logic        key_f_d;
   logic [2:0]  tries_d;

   // Only the lowest rising key of a simultaneous group is taken.
   always_comb begin
      rise_d  = lk.key_deb & ~key_prev_q;
      press_d = |rise_d;
      idx_d   = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (rise_d[i]) idx_d = 4'(i);
      end
      key_f_d = (idx_d == 4'hF);
      tries_d = tries_q + 3'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_ENTRY;
         key_prev_q    <= '0;
         entry_q       <= '0;
         digit_cnt_q   <= '0;
         tries_q       <= '0;
         digit_valid_q <= 1'b0;
         unlock_q      <= 1'b0;
         fail_q        <= 1'b0;
         locked_q      <= 1'b0;
         lock_cnt_q    <= '0;
`ifdef AUTO_RELOCK_EN
         open_cnt_q    <= '0;
`endif
      end else begin
         key_prev_q    <= lk.key_deb;
         digit_valid_q <= 1'b0;
         fail_q        <= 1'b0;
         case (state_q)
            ST_ENTRY: begin
               if (press_d) begin
                  if (key_f_d) begin
                     entry_q     <= '0;
                     digit_cnt_q <= '0;
                  end else begin
                     entry_q       <= {entry_q[11:0], idx_d};
                     digit_cnt_q   <= digit_cnt_q + 3'd1;
                     digit_valid_q <= 1'b1;
                     if (digit_cnt_q == 3'd3) state_q <= ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               entry_q     <= '0;
               digit_cnt_q <= '0;
               if (entry_q == CODE) begin
                  state_q  <= ST_OPEN;
                  unlock_q <= 1'b1;
                  tries_q  <= '0;
`ifdef AUTO_RELOCK_EN
                  open_cnt_q <= OPEN_CYCLES - 32'd1;
`endif
               end else begin
                  fail_q  <= 1'b1;
                  tries_q <= tries_d;
                  if (tries_d == MAX_T) begin
                     state_q    <= ST_LOCKOUT;
                     locked_q   <= 1'b1;
                     lock_cnt_q <= LOCK_CYCLES - 32'd1;
                  end else begin
                     state_q <= ST_ENTRY;
                  end
               end
            end
            ST_OPEN: begin
               if (press_d && key_f_d) begin
                  state_q  <= ST_ENTRY;
                  unlock_q <= 1'b0;
               end
`ifdef AUTO_RELOCK_EN
               else if (open_cnt_q == 32'd0) begin
                  state_q  <= ST_ENTRY;
                  unlock_q <= 1'b0;
               end else begin
                  open_cnt_q <= open_cnt_q - 32'd1;
               end
`endif
            end
            ST_LOCKOUT: begin
               // key_prev keeps tracking here so keys held at exit do not fire.
               if (lock_cnt_q == 32'd0) begin
                  state_q  <= ST_ENTRY;
                  locked_q <= 1'b0;
                  tries_q  <= '0;
               end else begin
                  lock_cnt_q <= lock_cnt_q - 32'd1;
               end
            end
            default: state_q <= ST_ENTRY;
         endcase
      end
   end

   assign lk.entry       = entry_q;
   assign lk.digit_cnt   = digit_cnt_q;
   assign lk.digit_valid = digit_valid_q;
   assign lk.unlock      = unlock_q;
   assign lk.fail        = fail_q;
   assign lk.locked      = locked_q;
   assign lk.tries_used  = tries_q;

endmodule

// File: tb/tb_key_code_lock.sv
// tb/tb_key_code_lock.sv - scoreboard bench for key_code_lock
module tb_key_code_lock;
   localparam int LOCK  = 10;
   localparam int OPENC = 20;
   localparam int MAXT  = 3;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   key_code_lock_if kif();

   key_code_lock #(
      .CODE        (16'h1234),
      .MAX_TRIES   (MAXT),
      .LOCK_CYCLES (32'(LOCK)),
      .OPEN_CYCLES (32'(OPENC))
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .lk   (kif)
   );

   int n_pass   = 0;
   int n_total  = 0;
   int dv_count = 0;
   logic [3:0] exp_q[$];
   logic [3:0] mon_exp;

   // Scoreboard: each accepted digit was queued when its key was driven.
   always @(negedge clk) begin
      if (rstn && kif.digit_valid === 1'b1) begin
         dv_count++;
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL digit_unexpected: got %h expected no digit", kif.entry[3:0]);
         end else begin
            mon_exp = exp_q.pop_front();
            if (kif.entry[3:0] !== mon_exp)
               $display("FAIL digit_value: got %h expected %h", kif.entry[3:0], mon_exp);
            else
               n_pass++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int k, input bit accept);
      if (accept && k != 15) exp_q.push_back(4'(k));
      kif.key_deb = 16'(1) << k;
      tick(3);
      kif.key_deb = '0;
      tick(3);
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      kif.key_deb = '0;
      tick(2);
      n_total++;
      if ({kif.entry, kif.digit_cnt, kif.digit_valid, kif.unlock, kif.fail, kif.locked, kif.tries_used} !== 26'd0)
         $display("FAIL reset_outputs: got entry=%h cnt=%0d unlock=%b locked=%b expected all zero",
                  kif.entry, kif.digit_cnt, kif.unlock, kif.locked);
      else n_pass++;
      rstn = 1'b1;
      tick(1);
      n_total++;
      if ({kif.entry, kif.digit_cnt, kif.unlock, kif.locked, kif.tries_used} !== 24'd0)
         $display("FAIL reset_release: got entry=%h cnt=%0d expected zero", kif.entry, kif.digit_cnt);
      else n_pass++;
   endtask

   task automatic test_unlock;
      press(1, 1); press(2, 1); press(3, 1);
      n_total++;
      if (kif.entry !== 16'h0123 || kif.digit_cnt !== 3'd3)
         $display("FAIL partial_entry: got %h/%0d expected 0123/3", kif.entry, kif.digit_cnt);
      else n_pass++;
      exp_q.push_back(4'h4);
      kif.key_deb = 16'h0010;
      tick(1);
      n_total++;
      if (kif.unlock !== 1'b0 || kif.entry !== 16'h1234 || kif.digit_cnt !== 3'd4)
         $display("FAIL fourth_digit: got unlock=%b entry=%h cnt=%0d expected 0/1234/4",
                  kif.unlock, kif.entry, kif.digit_cnt);
      else n_pass++;
      tick(1);
      n_total++;
      if (kif.unlock !== 1'b1 || kif.tries_used !== 3'd0 || kif.entry !== 16'h0)
         $display("FAIL unlock_latency: got unlock=%b tries=%0d entry=%h expected 1/0/0000",
                  kif.unlock, kif.tries_used, kif.entry);
      else n_pass++;
      kif.key_deb = '0;
      tick(3);
      kif.key_deb = 16'h8000;
      tick(1);
      n_total++;
      if (kif.unlock !== 1'b0)
         $display("FAIL relock_f: got unlock=%b expected 0", kif.unlock);
      else n_pass++;
      kif.key_deb = '0;
      tick(3);
   endtask

   task automatic test_lockout;
      int hi;
      for (int a = 1; a <= MAXT; a++) begin
         press(1, 1); press(2, 1); press(3, 1);
         exp_q.push_back(4'h5);
         kif.key_deb = 16'h0020;
         tick(2);
         n_total++;
         if (kif.fail !== 1'b1 || kif.tries_used !== 3'(a) || kif.locked !== (a == MAXT))
            $display("FAIL wrong_code_%0d: got fail=%b tries=%0d locked=%b expected 1/%0d/%b",
                     a, kif.fail, kif.tries_used, kif.locked, a, (a == MAXT));
         else n_pass++;
         kif.key_deb = '0;
         if (a < MAXT) begin
            tick(1);
            n_total++;
            if (kif.fail !== 1'b0)
               $display("FAIL fail_pulse_width: got %b expected 0", kif.fail);
            else n_pass++;
            tick(2);
         end
      end
      hi = 1;
      for (int c = 1; c < 40; c++) begin
         if (c == 2) kif.key_deb = 16'h0080;
         if (c == 4) kif.key_deb = '0;
         if (c == 7) kif.key_deb = 16'h0200;
         tick(1);
         if (kif.locked === 1'b1) hi++;
         else break;
      end
      n_total++;
      if (hi !== LOCK)
         $display("FAIL lockout_length: got %0d expected %0d", hi, LOCK);
      else n_pass++;
      tick(3);
      n_total++;
      if (kif.tries_used !== 3'd0 || kif.digit_cnt !== 3'd0 || kif.locked !== 1'b0)
         $display("FAIL lockout_exit: got tries=%0d cnt=%0d locked=%b expected 0/0/0",
                  kif.tries_used, kif.digit_cnt, kif.locked);
      else n_pass++;
      kif.key_deb = '0;
      tick(3);
   endtask

   task automatic test_clear;
      press(1, 1); press(2, 1);
      n_total++;
      if (kif.digit_cnt !== 3'd2)
         $display("FAIL clear_pre: got cnt=%0d expected 2", kif.digit_cnt);
      else n_pass++;
      press(15, 0);
      n_total++;
      if (kif.entry !== 16'h0 || kif.digit_cnt !== 3'd0)
         $display("FAIL clear_f: got entry=%h cnt=%0d expected 0000/0", kif.entry, kif.digit_cnt);
      else n_pass++;
      press(1, 1); press(2, 1); press(3, 1); press(4, 1);
      n_total++;
      if (kif.unlock !== 1'b1)
         $display("FAIL clear_then_code: got unlock=%b expected 1", kif.unlock);
      else n_pass++;
      press(15, 0);
      n_total++;
      if (kif.unlock !== 1'b0)
         $display("FAIL clear_relock: got unlock=%b expected 0", kif.unlock);
      else n_pass++;
   endtask

   task automatic test_multi_and_hold;
      int d0;
      d0 = dv_count;
      exp_q.push_back(4'h3);
      kif.key_deb = 16'h0088;
      tick(3);
      kif.key_deb = '0;
      tick(3);
      n_total++;
      if (dv_count - d0 !== 1 || kif.entry !== 16'h0003 || kif.digit_cnt !== 3'd1)
         $display("FAIL simultaneous_keys: got n=%0d entry=%h cnt=%0d expected 1/0003/1",
                  dv_count - d0, kif.entry, kif.digit_cnt);
      else n_pass++;
      exp_q.push_back(4'h5);
      kif.key_deb = 16'h0020;
      tick(100);
      kif.key_deb = '0;
      tick(3);
      n_total++;
      if (dv_count - d0 !== 2 || kif.entry !== 16'h0035)
         $display("FAIL held_key: got n=%0d entry=%h expected 2/0035", dv_count - d0, kif.entry);
      else n_pass++;
      press(15, 0);
   endtask

   task automatic test_open_timeout;
      int hi;
      press(1, 1); press(2, 1); press(3, 1);
      exp_q.push_back(4'h4);
      kif.key_deb = 16'h0010;
      tick(2);
      n_total++;
      if (kif.unlock !== 1'b1)
         $display("FAIL open_entry: got unlock=%b expected 1", kif.unlock);
      else n_pass++;
      kif.key_deb = '0;
      hi = 1;
      for (int c = 1; c < 60; c++) begin
         tick(1);
         if (kif.unlock === 1'b1) hi++;
         else break;
      end
`ifdef AUTO_RELOCK_EN
      n_total++;
      if (hi !== OPENC)
         $display("FAIL auto_relock: got %0d cycles expected %0d", hi, OPENC);
      else n_pass++;
`else
      n_total++;
      if (hi !== 60)
         $display("FAIL open_persist: got %0d cycles expected 60", hi);
      else n_pass++;
      press(15, 0);
      n_total++;
      if (kif.unlock !== 1'b0)
         $display("FAIL open_relock: got unlock=%b expected 0", kif.unlock);
      else n_pass++;
`endif
   endtask

   task automatic test_reset_mid;
      press(1, 1); press(2, 1); press(3, 1); press(4, 1);
      kif.key_deb = 16'h0040;
      tick(2);
      n_total++;
      if (kif.unlock !== 1'b1 || kif.digit_cnt !== 3'd0)
         $display("FAIL open_ignores: got unlock=%b cnt=%0d expected 1/0", kif.unlock, kif.digit_cnt);
      else n_pass++;
      #2 rstn = 1'b0;
      #1;
      n_total++;
      if ({kif.entry, kif.digit_cnt, kif.digit_valid, kif.unlock, kif.fail, kif.locked, kif.tries_used} !== 26'd0)
         $display("FAIL reset_mid_open: got unlock=%b entry=%h expected all zero", kif.unlock, kif.entry);
      else n_pass++;
      tick(1);
      exp_q.push_back(4'h6);
      rstn = 1'b1;
      tick(1);
      n_total++;
      if (kif.digit_cnt !== 3'd1 || kif.entry !== 16'h0006)
         $display("FAIL held_through_reset: got cnt=%0d entry=%h expected 1/0006", kif.digit_cnt, kif.entry);
      else n_pass++;
      kif.key_deb = '0;
      tick(3);
      press(15, 0);
      for (int a = 0; a < MAXT; a++) begin
         press(1, 1); press(2, 1); press(3, 1); press(5, 1);
      end
      n_total++;
      if (kif.locked !== 1'b1 || kif.tries_used !== 3'(MAXT))
         $display("FAIL lock_before_reset: got locked=%b tries=%0d expected 1/%0d",
                  kif.locked, kif.tries_used, MAXT);
      else n_pass++;
      #2 rstn = 1'b0;
      #1;
      n_total++;
      if ({kif.entry, kif.digit_cnt, kif.digit_valid, kif.unlock, kif.fail, kif.locked, kif.tries_used} !== 26'd0)
         $display("FAIL reset_mid_lockout: got locked=%b tries=%0d expected all zero", kif.locked, kif.tries_used);
      else n_pass++;
      tick(1);
      rstn = 1'b1;
      tick(1);
      press(7, 1);
      n_total++;
      if (kif.locked !== 1'b0 || kif.digit_cnt !== 3'd1 || kif.entry !== 16'h0007)
         $display("FAIL entry_after_reset: got locked=%b cnt=%0d entry=%h expected 0/1/0007",
                  kif.locked, kif.digit_cnt, kif.entry);
      else n_pass++;
      press(15, 0);
   endtask

   initial begin
      kif.key_deb = '0;
      test_reset();
      test_unlock();
      test_lockout();
      test_clear();
      test_multi_and_hold();
      test_open_timeout();
      test_reset_mid();
      tick(3);
      n_total++;
      if (exp_q.size() != 0)
         $display("FAIL digits_missing: got %0d pending expected 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
